// File: rtl/gbclk_sequencer_if.sv
// Command channel into the GameBoy clock sequencer: op/arg/align with a
// valid/ready handshake.
interface gbclk_sequencer_if #(
  parameter int CNT_W = 32
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_arg;
  logic [1:0]       align;

  modport master (output cmd_valid, cmd_op, cmd_arg, align, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_arg, align, output cmd_ready);
endinterface

// File: rtl/gbclk_sequencer.sv
// Drives the GameBoy X1 clock from a fabric-clock divider: free-run, run N
// ticks, or stop on a tick-count alignment, plus a one-shot bus-read timestamp.
module gbclk_sequencer #(
  parameter int DIV_W = 4,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  gbclk_sequencer_if.slave     cmd,
  output logic                 gb_clk,
  output logic                 tick,
  output logic                 busy,
  output logic [CNT_W-1:0]     count,
  input  logic [15:0]          bus_adr,
  input  logic                 bus_nrd,
  input  logic                 bus_ncs,
  input  logic                 trig_en,
  input  logic [15:0]          trig_adr,
  output logic                 trig_hit,
  output logic [CNT_W-1:0]     trig_at
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RUN_N, S_STOPPING} state_t;

  localparam logic [1:0] OP_STOP  = 2'd0;
  localparam logic [1:0] OP_RUN   = 2'd1;
  localparam logic [1:0] OP_RUN_N = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam logic [DIV_W-1:0] DIV_TICK = {1'b0, {(DIV_W-1){1'b1}}};
  localparam logic [DIV_W-1:0] DIV_LAST = {DIV_W{1'b1}};

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_inc, cnt_d;
  logic [1:0]       align_q, align_d;
  logic             drain_q, drain_d;
  logic             running, tick_now, wrap_now, tick_d, gb_d;
  logic             accept, clr, trig_fire;

  assign running  = (state_q != S_IDLE);
  assign tick_now = running && (div_q == DIV_TICK);
  assign wrap_now = running && (div_q == DIV_LAST);
  assign cnt_inc  = count + CNT_W'(1);

  assign cmd.cmd_ready = (state_q == S_IDLE) ||
                         (((state_q == S_RUN) || (state_q == S_RUN_N)) && (cmd.cmd_op == OP_STOP));
  assign accept = cmd.cmd_valid && cmd.cmd_ready;

  // drain_q: no further ticks wanted, leave to IDLE when the high phase completes
  always_comb begin
    state_d = state_q;
    div_d   = running ? div_q + DIV_W'(1) : '0;
    rem_d   = rem_q;
    drain_d = drain_q;
    align_d = align_q;
    tick_d  = tick_now;
    clr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        drain_d = 1'b0;
        if (accept) begin
          case (cmd.cmd_op)
            OP_RUN:   state_d = S_RUN;
            OP_RUN_N: if (cmd.cmd_arg != '0) begin
              state_d = S_RUN_N;
              rem_d   = cmd.cmd_arg;
            end
            OP_CLEAR: clr = 1'b1;
            default: ;
          endcase
        end
      end
      S_RUN, S_RUN_N: begin
        if ((state_q == S_RUN_N) && tick_now) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = S_STOPPING;
            drain_d = 1'b1;
          end
        end
        // STOP discards any remaining RUN_N ticks
        if (accept) begin
          align_d = cmd.align;
          if (!gb_clk && (count[1:0] == cmd.align)) begin
            state_d = S_IDLE;
            div_d   = '0;
            tick_d  = 1'b0;
            drain_d = 1'b0;
          end else begin
            state_d = S_STOPPING;
            drain_d = tick_now && (cnt_inc[1:0] == cmd.align);
          end
        end
      end
      S_STOPPING: begin
        if (tick_now && (cnt_inc[1:0] == align_q)) drain_d = 1'b1;
        if (drain_q && wrap_now) begin
          state_d = S_IDLE;
          drain_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    gb_d  = (state_d != S_IDLE) && div_d[DIV_W-1];
    cnt_d = clr ? '0 : (tick_d ? cnt_inc : count);
  end

  assign trig_fire = tick_d && trig_en && !trig_hit && !bus_nrd && !bus_ncs && (bus_adr == trig_adr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      rem_q    <= '0;
      align_q  <= '0;
      drain_q  <= 1'b0;
      gb_clk   <= 1'b0;
      tick     <= 1'b0;
      busy     <= 1'b0;
      count    <= '0;
      trig_hit <= 1'b0;
      trig_at  <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
      align_q  <= align_d;
      drain_q  <= drain_d;
      gb_clk   <= gb_d;
      tick     <= tick_d;
      busy     <= (state_d != S_IDLE);
      count    <= cnt_d;
      trig_hit <= clr ? 1'b0 : (trig_hit | trig_fire);
      trig_at  <= clr ? '0 : (trig_fire ? count : trig_at);
    end
  end

endmodule

// File: tb/tb_gbclk_sequencer.sv
// Scoreboard bench: a phase/tick-level reference model predicts every output
// each cycle; a monitor pops predictions and compares them with the DUT.
module tb_gbclk_sequencer;
  localparam int DIV_W = 4;
  localparam int CNT_W = 8;
  localparam int PER   = 1 << DIV_W;
  localparam int HALF  = PER / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gbclk_sequencer_if #(.CNT_W(CNT_W)) cif ();

  logic             gb_clk, tick, busy, trig_hit;
  logic [CNT_W-1:0] count, trig_at;
  logic [15:0]      bus_adr  = 16'h0000;
  logic [15:0]      trig_adr = 16'h0100;
  logic             bus_nrd  = 1'b1;
  logic             bus_ncs  = 1'b1;
  logic             trig_en  = 1'b0;

  gbclk_sequencer #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd(cif.slave),
    .gb_clk(gb_clk), .tick(tick), .busy(busy), .count(count),
    .bus_adr(bus_adr), .bus_nrd(bus_nrd), .bus_ncs(bus_ncs),
    .trig_en(trig_en), .trig_adr(trig_adr),
    .trig_hit(trig_hit), .trig_at(trig_at)
  );

  typedef struct { bit rdy; bit gb; bit tk; bit bsy; bit hit; int cnt; int at; } exp_t;
  exp_t q[$];

  // reference model: phase within the gb_clk period plus run bookkeeping
  bit m_act, m_stopreq, m_end, m_gb, m_tk, m_hit, m_acc;
  int m_ph, m_left, m_cnt, m_at, m_al;
  int n_cmp = 0, n_bad = 0;

  // values applied to the DUT at the next falling edge
  bit nx_rst = 1'b1, nx_trig_en = 1'b0, nx_nrd = 1'b1, nx_ncs = 1'b1;
  logic [15:0] nx_adr = 16'h0000;

  function automatic bit m_ready(input logic [1:0] op);
    if (!m_act) return 1'b1;
    if (m_stopreq || m_end) return 1'b0;
    return op == 2'd0;
  endfunction

  task automatic model_reset();
    m_act = 0; m_stopreq = 0; m_end = 0; m_gb = 0; m_tk = 0; m_hit = 0;
    m_ph = 0; m_left = -1; m_cnt = 0; m_at = 0; m_al = 0;
  endtask

  task automatic model_step();
    bit t;
    m_tk  = 0;
    m_acc = 0;
    if (rst) begin model_reset(); return; end
    m_acc = cif.cmd_valid && m_ready(cif.cmd_op);
    if (!m_act) begin
      if (m_acc) begin
        case (cif.cmd_op)
          2'd1: begin m_act = 1; m_left = -1; end
          2'd2: if (cif.cmd_arg != 0) begin m_act = 1; m_left = int'(cif.cmd_arg); end
          2'd3: begin m_cnt = 0; m_hit = 0; m_at = 0; end
          default: ;
        endcase
      end
      m_ph = 0; m_gb = 0;
      return;
    end
    if (m_acc) begin
      if (!m_gb && (m_cnt % 4) == int'(cif.align)) begin
        m_act = 0; m_ph = 0; m_gb = 0; m_left = -1; m_stopreq = 0; m_end = 0;
        return;
      end
      m_stopreq = 1; m_left = -1; m_al = int'(cif.align);
    end
    t = (m_ph == HALF - 1);
    m_ph = (m_ph + 1) % PER;
    if (t) begin
      if (trig_en && !m_hit && !bus_nrd && !bus_ncs && bus_adr == trig_adr) begin
        m_hit = 1; m_at = m_cnt;
      end
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (m_left > 0) begin m_left--; if (m_left == 0) m_end = 1; end
      if (m_stopreq && (m_cnt % 4) == m_al) begin m_stopreq = 0; m_end = 1; end
    end
    m_tk = t;
    if (m_end && m_ph == 0) begin m_act = 0; m_end = 0; m_left = -1; end
    m_gb = (m_ph >= HALF);
  endtask

  task automatic cyc(input bit v, input logic [1:0] op, input int arg, input logic [1:0] al);
    exp_t e;
    @(negedge clk);
    rst = nx_rst; trig_en = nx_trig_en; bus_adr = nx_adr; bus_nrd = nx_nrd; bus_ncs = nx_ncs;
    cif.cmd_valid = v; cif.cmd_op = op; cif.cmd_arg = CNT_W'(arg); cif.align = al;
    e.rdy = m_ready(op); e.gb = m_gb; e.tk = m_tk; e.bsy = m_act;
    e.hit = m_hit; e.cnt = m_cnt; e.at = m_at;
    q.push_back(e);
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 0, 2'd0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    #3;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("cmd_ready", 32'(cif.cmd_ready), 32'(e.rdy));
      chk("gb_clk",    32'(gb_clk),        32'(e.gb));
      chk("tick",      32'(tick),          32'(e.tk));
      chk("busy",      32'(busy),          32'(e.bsy));
      chk("count",     32'(count),         32'(e.cnt));
      chk("trig_hit",  32'(trig_hit),      32'(e.hit));
      chk("trig_at",   32'(trig_at),       32'(e.at));
    end
  end

  initial begin
    bit pend;
    logic [1:0] pop, pal;
    int parg, r, guard;
    cif.cmd_valid = 0; cif.cmd_op = 0; cif.cmd_arg = 0; cif.align = 0;
    repeat (2) @(posedge clk);
    model_reset();
    nx_rst = 0;
    idle(3);

    // RUN_N 0 is a no-op, RUN_N 5 delivers five ticks
    cyc(1, 2'd2, 0, 0); idle(20);
    cyc(1, 2'd2, 5, 0); idle(100);

    // free run, stop on alignment from mid-run, then an immediate stop
    cyc(1, 2'd1, 0, 0); idle(37);
    cyc(1, 2'd0, 0, 2'd2); idle(90);
    cyc(1, 2'd1, 0, 0);
    cyc(1, 2'd1, 0, 0); cyc(1, 2'd3, 0, 0);
    guard = 0;
    while (!(m_act && !m_gb && m_ph == 2) && guard < 64) begin idle(1); guard++; end
    cyc(1, 2'd0, 0, 2'(m_cnt % 4));
    idle(20);

    // trigger: first hit timestamped, later hit ignored, CLEAR zeroes
    nx_trig_en = 1; nx_adr = 16'h0100; nx_nrd = 0; nx_ncs = 0;
    cyc(1, 2'd2, 3, 0); idle(60);
    cyc(1, 2'd2, 2, 0); idle(45);
    nx_trig_en = 0; nx_nrd = 1; nx_ncs = 1;
    cyc(1, 2'd3, 0, 0); idle(3);

    // STOP while already stopping stalls
    cyc(1, 2'd1, 0, 0); idle(10);
    cyc(1, 2'd0, 0, 2'd3); cyc(1, 2'd0, 0, 2'd3); idle(80);

    // reset in the middle of a high phase
    cyc(1, 2'd1, 0, 0);
    guard = 0;
    while (!(m_act && m_ph == HALF + 3) && guard < 64) begin idle(1); guard++; end
    nx_rst = 1; idle(1); nx_rst = 0; idle(3);

    // count wraps at 2^CNT_W
    cyc(1, 2'd1, 0, 0);
    guard = 0;
    while (m_cnt != (1 << CNT_W) - 2 && guard < 6000) begin idle(1); guard++; end
    idle(60);
    cyc(1, 2'd0, 0, 2'd1); idle(80);

    // randomized traffic; a pending command is held until accepted
    pend = 0; pop = 0; parg = 0; pal = 0;
    for (int i = 0; i < 30000; i++) begin
      nx_rst = ($urandom_range(0, 3999) == 0);
      if ($urandom_range(0, 499) == 0) nx_trig_en = !nx_trig_en;
      nx_adr = ($urandom_range(0, 3) == 0) ? 16'h0100 : 16'($urandom);
      nx_nrd = 1'($urandom_range(0, 1));
      nx_ncs = 1'($urandom_range(0, 1));
      if (!pend && $urandom_range(0, 11) == 0) begin
        pend = 1;
        r = $urandom_range(0, 99);
        pop = (r < 40) ? 2'd0 : (r < 65) ? 2'd1 : (r < 95) ? 2'd2 : 2'd3;
        parg = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
        pal = 2'($urandom_range(0, 3));
      end
      cyc(pend, pop, parg, pal);
      if (m_acc || rst) pend = 0;
    end
    nx_rst = 0;
    idle(2);

    @(negedge clk); #5;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
